// File: rtl/escalonador_rr.sv
// Preemptive round-robin scheduler: pid 0 is the OS (always ready), pids 1..3 are user processes.
// Drives the running pid and a one-cycle context-switch strobe for the PC manager and register bank.
module escalonador_rr #(
    parameter int unsigned QUANTUM = 64,
    parameter int unsigned QW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          HALT,
    input  logic          WAIT,
    input  logic          Set_ctx,
    input  logic          Set_pid_0,
    input  logic [1:0]    pid_req,
    input  logic          load_valid,
    input  logic [1:0]    load_pid,
    input  logic          io_done,
    input  logic [1:0]    io_pid,
    output logic [1:0]    id_proc,
    output logic          troca_ctx,
    output logic [3:0]    ready_mask,
    output logic [3:0]    wait_mask,
    output logic [QW-1:0] quantum_left,
    output logic          idle
);

    localparam logic [QW-1:0] Reload = QW'(QUANTUM - 1);

    typedef enum logic [0:0] {StRun, StSwitch} state_e;

    state_e        state_q, state_d;
    logic [1:0]    id_q, id_d;
    logic [1:0]    next_q, next_d;
    logic [1:0]    last_q, last_d;
    logic [3:0]    ready_q, ready_d;
    logic [3:0]    wait_q, wait_d;
    logic [QW-1:0] quant_q, quant_d;

    logic [3:0] cur_onehot;
    logic [3:1] cand;
    logic [1:0] rr_pid;
    logic       clear_ev;
    logic       os_ev;
    logic       ctx_ev;
    logic       exp_ev;

    assign cur_onehot = 4'b0001 << id_q;
    assign clear_ev   = HALT | WAIT;
    assign os_ev      = Set_pid_0 && (id_q != 2'd0);
    assign ctx_ev     = Set_ctx && ready_q[pid_req] && (pid_req != id_q);
    assign exp_ev     = enable && (quant_q == '0);

    // The process being halted/blocked is not a candidate for its own replacement.
    always_comb begin
        cand = ready_q[3:1];
        if (clear_ev) begin
            cand = ready_q[3:1] & ~cur_onehot[3:1];
        end
    end

    // Walk last_user+3 down to last_user+1 so the nearest ready pid wins.
    always_comb begin
        logic [1:0] p;
        rr_pid = 2'd0;
        p      = 2'd0;
        for (int i = 3; i >= 1; i--) begin
            p = 2'((int'(last_q) + i - 1) % 3 + 1);
            if (cand[p]) begin
                rr_pid = p;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        next_d  = next_q;
        last_d  = last_q;
        ready_d = ready_q;
        wait_d  = wait_q;
        quant_d = quant_q;

        unique case (state_q)
            StRun: begin
                if (clear_ev || (!os_ev && !ctx_ev && exp_ev)) begin
                    if (HALT) begin
                        ready_d = ready_q & ~cur_onehot;
                    end else if (WAIT) begin
                        ready_d = ready_q & ~cur_onehot;
                        wait_d  = wait_q | cur_onehot;
                    end
                    if (rr_pid == id_q) begin
                        quant_d = Reload;
                    end else begin
                        next_d  = rr_pid;
                        state_d = StSwitch;
                    end
                end else if (os_ev) begin
                    next_d  = 2'd0;
                    state_d = StSwitch;
                end else if (ctx_ev) begin
                    next_d  = pid_req;
                    state_d = StSwitch;
                end else if (enable) begin
                    quant_d = quant_q - QW'(1);
                end
            end
            StSwitch: begin
                id_d    = next_q;
                quant_d = Reload;
                state_d = StRun;
                if (next_q != 2'd0) begin
                    last_d = next_q;
                end
            end
        endcase

        // Loader and I/O sets override a same-edge clear and apply in every state.
        if (load_valid && (load_pid != 2'd0)) begin
            ready_d[load_pid] = 1'b1;
            wait_d[load_pid]  = 1'b0;
        end
        if (io_done && (io_pid != 2'd0)) begin
            if (wait_q[io_pid]) begin
                ready_d[io_pid] = 1'b1;
            end
            wait_d[io_pid] = 1'b0;
        end
        ready_d[0] = 1'b1;
        wait_d[0]  = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            id_q    <= 2'd0;
            next_q  <= 2'd0;
            last_q  <= 2'd0;
            ready_q <= 4'b0001;
            wait_q  <= 4'b0000;
            quant_q <= Reload;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            next_q  <= next_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            wait_q  <= wait_d;
            quant_q <= quant_d;
        end
    end

    assign id_proc      = id_q;
    assign troca_ctx    = (state_q == StSwitch);
    assign ready_mask   = ready_q;
    assign wait_mask    = wait_q;
    assign quantum_left = quant_q;
    assign idle         = (id_q == 2'd0) && (ready_q[3:1] == 3'b000);

    a_switch_one_cycle: assert property (
        @(posedge clk) disable iff (!reset) (state_q == StSwitch) |=> (state_q == StRun));
    a_os_always_ready: assert property (
        @(posedge clk) disable iff (!reset) (ready_q[0] && !wait_q[0]));

endmodule

// File: tb/tb_escalonador_rr.sv
// Directed bench for escalonador_rr with QUANTUM=4: reset, timer preemption, I/O wait,
// OS dispatch, event priority/collisions, enable freeze and reset during a switch.
module tb_escalonador_rr;

    localparam int unsigned QUANTUM = 4;
    localparam int unsigned QW      = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          HALT;
    logic          WAIT;
    logic          Set_ctx;
    logic          Set_pid_0;
    logic [1:0]    pid_req;
    logic          load_valid;
    logic [1:0]    load_pid;
    logic          io_done;
    logic [1:0]    io_pid;
    logic [1:0]    id_proc;
    logic          troca_ctx;
    logic [3:0]    ready_mask;
    logic [3:0]    wait_mask;
    logic [QW-1:0] quantum_left;
    logic          idle;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    escalonador_rr #(
        .QUANTUM(QUANTUM),
        .QW     (QW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .HALT        (HALT),
        .WAIT        (WAIT),
        .Set_ctx     (Set_ctx),
        .Set_pid_0   (Set_pid_0),
        .pid_req     (pid_req),
        .load_valid  (load_valid),
        .load_pid    (load_pid),
        .io_done     (io_done),
        .io_pid      (io_pid),
        .id_proc     (id_proc),
        .troca_ctx   (troca_ctx),
        .ready_mask  (ready_mask),
        .wait_mask   (wait_mask),
        .quantum_left(quantum_left),
        .idle        (idle)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; HALT = 1'b0; WAIT = 1'b0;
        Set_ctx = 1'b0; Set_pid_0 = 1'b0; pid_req = 2'd0;
        load_valid = 1'b0; load_pid = 2'd0; io_done = 1'b0; io_pid = 2'd0;
        #12;
        total++;
        if ({id_proc, troca_ctx, ready_mask, wait_mask, idle} !== {2'd0, 1'b0, 4'b0001, 4'b0000, 1'b1})
            $display("FAIL reset_outputs: got %b required %b",
                     {id_proc, troca_ctx, ready_mask, wait_mask, idle}, 12'b00_0_0001_0000_1);
        else passed++;
        total++;
        if (quantum_left !== 16'd3)
            $display("FAIL reset_quantum: got %0d required 3", quantum_left);
        else passed++;
        reset = 1'b1;
        step();
        total++;
        if ({id_proc, troca_ctx, quantum_left} !== {2'd0, 1'b0, 16'd3})
            $display("FAIL reset_release: got id=%0d troca=%b q=%0d required id=0 troca=0 q=3",
                     id_proc, troca_ctx, quantum_left);
        else passed++;
    endtask

    task automatic test_expiry_no_user();
        logic [15:0] exp_q;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            exp_q = (k < 3) ? 16'(2 - k) : 16'd3;
            total++;
            if ({troca_ctx, id_proc, quantum_left} !== {1'b0, 2'd0, exp_q})
                $display("FAIL expiry_idle[%0d]: got troca=%b id=%0d q=%0d required troca=0 id=0 q=%0d",
                         k, troca_ctx, id_proc, quantum_left, exp_q);
            else passed++;
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_freeze();
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if ({troca_ctx, quantum_left} !== {1'b0, 16'd3})
                $display("FAIL freeze[%0d]: got troca=%b q=%0d required troca=0 q=3",
                         k, troca_ctx, quantum_left);
            else passed++;
        end
    endtask

    task automatic test_timer_preempt();
        logic [1:0] exp_old [3];
        logic [1:0] exp_new [3];
        int         n;
        logic       seen;
        exp_old[0] = 2'd0; exp_old[1] = 2'd1; exp_old[2] = 2'd2;
        exp_new[0] = 2'd1; exp_new[1] = 2'd2; exp_new[2] = 2'd1;
        load_valid = 1'b1; load_pid = 2'd1;
        step();
        load_pid = 2'd2;
        step();
        load_valid = 1'b0;
        total++;
        if ({ready_mask, idle} !== {4'b0111, 1'b0})
            $display("FAIL load_ready: got ready=%b idle=%b required ready=0111 idle=0",
                     ready_mask, idle);
        else passed++;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0; seen = 1'b0;
            while (!seen && n < 20) begin
                step();
                n++;
                if (troca_ctx === 1'b1) seen = 1'b1;
            end
            total++;
            if (!seen || n != 4)
                $display("FAIL slice_len[%0d]: got seen=%b cycles=%0d required seen=1 cycles=4",
                         k, seen, n);
            else passed++;
            total++;
            if (id_proc !== exp_old[k])
                $display("FAIL pulse_id[%0d]: got %0d required %0d", k, id_proc, exp_old[k]);
            else passed++;
            step();
            total++;
            if ({troca_ctx, id_proc, quantum_left} !== {1'b0, exp_new[k], 16'd3})
                $display("FAIL preempt_new[%0d]: got troca=%b id=%0d q=%0d required troca=0 id=%0d q=3",
                         k, troca_ctx, id_proc, quantum_left, exp_new[k]);
            else passed++;
        end
        enable = 1'b0;
    endtask

    task automatic test_wait_io();
        int   n;
        logic seen;
        WAIT = 1'b1;
        step();
        WAIT = 1'b0;
        total++;
        if ({troca_ctx, ready_mask, wait_mask} !== {1'b1, 4'b0101, 4'b0010})
            $display("FAIL wait_masks: got troca=%b ready=%b wait=%b required troca=1 ready=0101 wait=0010",
                     troca_ctx, ready_mask, wait_mask);
        else passed++;
        step();
        total++;
        if ({troca_ctx, id_proc} !== {1'b0, 2'd2})
            $display("FAIL wait_switch: got troca=%b id=%0d required troca=0 id=2", troca_ctx, id_proc);
        else passed++;
        io_done = 1'b1; io_pid = 2'd1;
        step();
        io_done = 1'b0;
        total++;
        if ({ready_mask, wait_mask} !== {4'b0111, 4'b0000})
            $display("FAIL io_done: got ready=%b wait=%b required ready=0111 wait=0000",
                     ready_mask, wait_mask);
        else passed++;
        enable = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            step();
            n++;
            if (troca_ctx === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || n != 4)
            $display("FAIL io_expiry: got seen=%b cycles=%0d required seen=1 cycles=4", seen, n);
        else passed++;
        step();
        enable = 1'b0;
        total++;
        if (id_proc !== 2'd1)
            $display("FAIL io_resched: got %0d required 1", id_proc);
        else passed++;
    endtask

    task automatic test_os_dispatch();
        Set_pid_0 = 1'b1;
        step();
        Set_pid_0 = 1'b0;
        total++;
        if ({troca_ctx, id_proc} !== {1'b1, 2'd1})
            $display("FAIL yield_pulse: got troca=%b id=%0d required troca=1 id=1", troca_ctx, id_proc);
        else passed++;
        step();
        total++;
        if (id_proc !== 2'd0)
            $display("FAIL yield_id: got %0d required 0", id_proc);
        else passed++;
        Set_ctx = 1'b1; pid_req = 2'd2;
        step();
        Set_ctx = 1'b0;
        total++;
        if (troca_ctx !== 1'b1)
            $display("FAIL dispatch_pulse: got %b required 1", troca_ctx);
        else passed++;
        step();
        total++;
        if (id_proc !== 2'd2)
            $display("FAIL dispatch_id: got %0d required 2", id_proc);
        else passed++;
        Set_ctx = 1'b1; pid_req = 2'd3;
        step();
        Set_ctx = 1'b0;
        total++;
        if ({troca_ctx, id_proc} !== {1'b0, 2'd2})
            $display("FAIL dispatch_unready: got troca=%b id=%0d required troca=0 id=2",
                     troca_ctx, id_proc);
        else passed++;
        Set_pid_0 = 1'b1;
        step();
        Set_pid_0 = 1'b0;
        HALT = 1'b1;
        step();
        HALT = 1'b0;
        total++;
        if ({troca_ctx, id_proc, ready_mask} !== {1'b0, 2'd0, 4'b0111})
            $display("FAIL halt_in_switch: got troca=%b id=%0d ready=%b required troca=0 id=0 ready=0111",
                     troca_ctx, id_proc, ready_mask);
        else passed++;
    endtask

    task automatic test_priority();
        Set_ctx = 1'b1; pid_req = 2'd2;
        step();
        Set_ctx = 1'b0;
        step();
        total++;
        if (id_proc !== 2'd2)
            $display("FAIL prio_setup: got %0d required 2", id_proc);
        else passed++;
        HALT = 1'b1; Set_pid_0 = 1'b1;
        step();
        HALT = 1'b0; Set_pid_0 = 1'b0;
        total++;
        if ({troca_ctx, ready_mask} !== {1'b1, 4'b0011})
            $display("FAIL halt_wins: got troca=%b ready=%b required troca=1 ready=0011",
                     troca_ctx, ready_mask);
        else passed++;
        step();
        total++;
        if (id_proc !== 2'd1)
            $display("FAIL halt_next: got %0d required 1", id_proc);
        else passed++;
        load_valid = 1'b1; load_pid = 2'd2;
        step();
        load_valid = 1'b0;
        Set_ctx = 1'b1; pid_req = 2'd2;
        step();
        Set_ctx = 1'b0;
        step();
        total++;
        if (id_proc !== 2'd2)
            $display("FAIL reload_dispatch: got %0d required 2", id_proc);
        else passed++;
        HALT = 1'b1; load_valid = 1'b1; load_pid = 2'd2;
        step();
        HALT = 1'b0; load_valid = 1'b0;
        total++;
        if ({troca_ctx, ready_mask} !== {1'b1, 4'b0111})
            $display("FAIL set_wins: got troca=%b ready=%b required troca=1 ready=0111",
                     troca_ctx, ready_mask);
        else passed++;
        step();
        total++;
        if (id_proc !== 2'd1)
            $display("FAIL set_keeps_next: got %0d required 1", id_proc);
        else passed++;
    endtask

    task automatic test_reset_mid_switch();
        Set_pid_0 = 1'b1;
        step();
        Set_pid_0 = 1'b0;
        total++;
        if ({troca_ctx, id_proc} !== {1'b1, 2'd1})
            $display("FAIL mid_pulse: got troca=%b id=%0d required troca=1 id=1", troca_ctx, id_proc);
        else passed++;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({troca_ctx, id_proc, ready_mask} !== {1'b0, 2'd0, 4'b0001})
            $display("FAIL async_reset: got troca=%b id=%0d ready=%b required troca=0 id=0 ready=0001",
                     troca_ctx, id_proc, ready_mask);
        else passed++;
        #2;
        reset = 1'b1;
        step();
        total++;
        if ({troca_ctx, id_proc, quantum_left} !== {1'b0, 2'd0, 16'd3})
            $display("FAIL post_reset: got troca=%b id=%0d q=%0d required troca=0 id=0 q=3",
                     troca_ctx, id_proc, quantum_left);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_expiry_no_user();
        test_enable_freeze();
        test_timer_preempt();
        test_wait_io();
        test_os_dispatch();
        test_priority();
        test_reset_mid_switch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/escalonador_rr.md
Name: escalonador_rr

Overview:
- Preemptive round-robin process scheduler for the single-cycle core.
- Owns the running process ID and the context-switch strobe that the PC manager and register bank use to swap per-process state.
- Reacts to core control events (halt, I/O wait, OS dispatch/return) and to a quantum timer.
- Sequences which of four processes drives the datapath: pid 0 is the OS and is always ready; pids 1..3 are user processes.

Parameters:
- QUANTUM, 64, time slice length in clk cycles (valid range 2..65535).
- QW, 16, quantum counter width in bits.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  preemption enable (preemp_mode); 0 = quantum counter frozen, no timer preemption
- HALT  in  1  current process executed halt
- WAIT  in  1  current process blocked on I/O
- Set_ctx  in  1  OS requests dispatch of pid_req
- Set_pid_0  in  1  current process yields to OS
- pid_req  in  2  target pid for Set_ctx
- load_valid  in  1  loader marks load_pid ready
- load_pid  in  2  pid being loaded
- io_done  in  1  I/O completed for io_pid
- io_pid  in  2  pid whose I/O completed
- id_proc  out  2  running process ID
- troca_ctx  out  1  one-cycle context-switch strobe
- ready_mask  out  4  ready[3:0]; bit 0 always 1
- wait_mask  out  4  processes blocked on I/O; bit 0 always 0
- quantum_left  out  QW  remaining cycles of current slice
- idle  out  1  id_proc==0 and ready[3:1]==0

Behaviour:
- Reset (reset=0, async), all outputs and state:
  - id_proc=0, troca_ctx=0, ready=4'b0001, wait=0
  - quantum_left=QUANTUM-1, state=RUN, next_pid=0, last_user=0
- States:
  - RUN: normal execution.
  - SWITCH: exactly one cycle with troca_ctx=1. On its exit edge: id_proc<=next_pid, quantum_left<=QUANTUM-1, state<=RUN.
- Event priority in RUN, highest first:
  - HALT: clear ready[cur].
  - WAIT: clear ready[cur], set wait[cur].
  - Set_pid_0: next_pid=0.
  - Set_ctx: accepted only if ready[pid_req]=1 and pid_req!=cur; otherwise ignored, no switch.
  - Timer expiry: enable=1 and quantum_left==0.
- Applying HALT or WAIT to pid 0 does not clear ready[0] or set wait[0]; the event still triggers round-robin selection.
- Round-robin selection (HALT, WAIT, expiry):
  - Search user pids in order last_user+1, +2, +3 (mod 3 over 1..3), skipping cur when cur is being cleared.
  - Take the first with ready=1. If none, select 0.
  - If the selected pid equals cur, no switch: quantum reloads, stay in RUN.
- Latency: event sampled at edge t, troca_ctx=1 during cycle t+1, new id_proc valid from edge t+2.
- last_user updates to next_pid on SWITCH exit when next_pid!=0.
- Quantum counter:
  - Decrements by 1 in RUN when enable=1; holds when enable=0.
  - At 0 with enable=1, expiry fires; the counter never wraps below 0.
  - On expiry it reloads to QUANTUM-1 in the same edge when no switch results.
- Mask updates apply in any state, including SWITCH:
  - load_valid sets ready[load_pid] and clears wait[load_pid].
  - io_done sets ready[io_pid] only if wait[io_pid]=1, then clears wait[io_pid].
  - load/io for pid 0 is ignored.
- Simultaneous events:
  - Set from load/io and clear from HALT/WAIT for the same pid on the same edge: set wins.
  - A set does not alter next_pid chosen on that edge.
- Control events (HALT, WAIT, Set_ctx, Set_pid_0, expiry) during SWITCH are ignored.
- Reset asserted mid-SWITCH: troca_ctx drops immediately and id_proc returns to 0.
- idle and ready_mask are combinational from registered state.

Test Plan:
- Reset: QUANTUM=4, release reset → id_proc=0, troca_ctx=0, ready_mask=0001, quantum_left=3, idle=1.
- Expiry with no user ready: enable=1 for 4 cycles → no troca_ctx pulse, quantum_left reloads to 3.
- Timer preemption sequence: load pids 1,2, enable=1 → id_proc sequence 0→1→2→1 at each expiry. Each troca_ctx pulse is exactly 1 cycle; new id_proc appears one cycle after the pulse. Slice length is 4 cycles of RUN.
- WAIT and I/O completion: pid 1 asserts WAIT → wait_mask=0010, ready_mask=0101, switch to 2. Then io_done with io_pid=1 → ready_mask=0111, wait_mask=0000; pid 1 is scheduled on the next expiry.
- OS dispatch: with id_proc=0, ready=0111, Set_ctx with pid_req=2 → switch to 2. Set_ctx with pid_req=3 while ready[3]=0 → ignored. Set_pid_0 from 2 → id_proc=0.
- Priority and collisions: HALT and Set_pid_0 on the same edge with id_proc=2, ready=0111 → HALT wins, ready_mask=0011, next id_proc=1. load_valid for pid 2 on that edge → ready_mask=0111 after the edge.
- enable=0 for 10 cycles → quantum_left frozen, no switch. Async reset asserted during the SWITCH cycle → troca_ctx=0 and id_proc=0 immediately.
